mem_bist_ctrl: RTL and testbench

MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

---
 rtl/mem_bist_ctrl_if.sv | 31 +++
 rtl/mem_bist_ctrl.sv | 156 +++++++++++++++
 tb/tb_mem_bist_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist_ctrl_if
// Brief    : Host bus and BIST control/status bundle for mem_bist_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_bist_ctrl_if #(
   parameter int ADDR_BITS = 7,
   parameter int DATA_BITS = 8
);
   logic                 we;
   logic [ADDR_BITS-1:0] addr;
   logic [DATA_BITS-1:0] wdata;
   logic [DATA_BITS-1:0] rdata;
   logic                 start;
   logic                 busy;
   logic                 done;
   logic                 fail;
   logic [ADDR_BITS-1:0] fail_addr;

   modport master (
      output we, addr, wdata, start,
      input  rdata, busy, done, fail, fail_addr
   );

   modport slave (
      input  we, addr, wdata, start,
      output rdata, busy, done, fail, fail_addr
   );
endinterface
`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist_ctrl
// Brief    : Register-array memory with host port and March C- self-test.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bist_ctrl #(
   parameter int ADDR_BITS = 7,
   parameter int DATA_BITS = 8
) (
   input  logic           clk,
   input  logic           reset,
   mem_bist_ctrl_if.slave bus
);
   localparam int                   DEPTH   = 2**ADDR_BITS;
   localparam logic [ADDR_BITS-1:0] CNT_MAX = '1;
   localparam logic [ADDR_BITS-1:0] CNT_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
   localparam logic [DATA_BITS-1:0] ZEROS   = '0;
   localparam logic [DATA_BITS-1:0] ONES    = '1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      M0   = 3'd1,
      M1   = 3'd2,
      M2   = 3'd3,
      M3   = 3'd4,
      M4   = 3'd5,
      M5   = 3'd6
   } state_t;

   state_t               state, state_nx;
   logic                 phase, phase_nx;
   logic [ADDR_BITS-1:0] cnt, cnt_nx;
   logic [DATA_BITS-1:0] mem [DEPTH];

   logic                 bist_we;
   logic [DATA_BITS-1:0] bist_wdata;
   logic                 rd_chk;
   logic [DATA_BITS-1:0] rd_exp;
   logic                 op_last;
   logic                 run_end;
   logic                 elem_up;
   logic                 elem_last;
   logic [DATA_BITS-1:0] rd_word;

   assign rd_word   = mem[cnt];
   assign elem_up   = (state == M0) || (state == M1) || (state == M2);
   assign elem_last = elem_up ? (cnt == CNT_MAX) : (cnt == '0);
   assign bus.busy  = (state != IDLE);

   // phase selects the read (0) or write (1) half of a read-write element
   always_comb begin
      state_nx   = state;
      phase_nx   = phase;
      cnt_nx     = cnt;
      bist_we    = 1'b0;
      bist_wdata = ZEROS;
      rd_chk     = 1'b0;
      rd_exp     = ZEROS;
      op_last    = 1'b0;
      run_end    = 1'b0;

      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = M0;
               cnt_nx   = '0;
               phase_nx = 1'b0;
            end
         end
         M0: begin
            bist_we = 1'b1;
            op_last = 1'b1;
         end
         M1, M2, M3, M4: begin
            if (!phase) begin
               rd_chk = 1'b1;
               rd_exp = ((state == M2) || (state == M4)) ? ONES : ZEROS;
            end else begin
               bist_we    = 1'b1;
               bist_wdata = ((state == M1) || (state == M3)) ? ONES : ZEROS;
               op_last    = 1'b1;
            end
         end
         M5: begin
            rd_chk  = 1'b1;
            op_last = 1'b1;
         end
         default: state_nx = IDLE;
      endcase

      if (state != IDLE) begin
         if (!op_last) begin
            phase_nx = 1'b1;
         end else begin
            phase_nx = 1'b0;
            if (!elem_last) begin
               cnt_nx = elem_up ? (cnt + CNT_ONE) : (cnt - CNT_ONE);
            end else begin
               // Reload the counter for the next element with no gap cycle
               case (state)
                  M0:      begin state_nx = M1; cnt_nx = '0;      end
                  M1:      begin state_nx = M2; cnt_nx = '0;      end
                  M2:      begin state_nx = M3; cnt_nx = CNT_MAX; end
                  M3:      begin state_nx = M4; cnt_nx = CNT_MAX; end
                  M4:      begin state_nx = M5; cnt_nx = CNT_MAX; end
                  default: begin state_nx = IDLE; cnt_nx = '0; run_end = 1'b1; end
               endcase
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         phase         <= 1'b0;
         cnt           <= '0;
         bus.done      <= 1'b0;
         bus.fail      <= 1'b0;
         bus.fail_addr <= '0;
         bus.rdata     <= '0;
      end else begin
         state <= state_nx;
         phase <= phase_nx;
         cnt   <= cnt_nx;
         if (state == IDLE) begin
            bus.rdata <= mem[bus.addr];
            if (bus.start) begin
               bus.done      <= 1'b0;
               bus.fail      <= 1'b0;
               bus.fail_addr <= '0;
            end
         end
         if (rd_chk && (rd_word != rd_exp) && !bus.fail) begin
            bus.fail      <= 1'b1;
            bus.fail_addr <= cnt;
         end
         if (run_end) begin
            bus.done <= 1'b1;
         end
      end
   end

   // Array contents survive reset; reset only blocks writes in its cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (bist_we) begin
            mem[cnt] <= bist_wdata;
         end else if ((state == IDLE) && bus.we) begin
            mem[bus.addr] <= bus.wdata;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bist_ctrl
// Brief    : Randomized self-checking bench for mem_bist_ctrl (two sizes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bist_ctrl;
   localparam int AB_A  = 7;
   localparam int DB_A  = 8;
   localparam int AB_B  = 2;
   localparam int DB_B  = 16;
   localparam int DEP_A = 1 << AB_A;
   localparam int DEP_B = 1 << AB_B;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_bist_ctrl_if #(.ADDR_BITS(AB_A), .DATA_BITS(DB_A)) ifa ();
   mem_bist_ctrl_if #(.ADDR_BITS(AB_B), .DATA_BITS(DB_B)) ifb ();

   mem_bist_ctrl #(.ADDR_BITS(AB_A), .DATA_BITS(DB_A)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   mem_bist_ctrl #(.ADDR_BITS(AB_B), .DATA_BITS(DB_B)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   int n_checks = 0;
   int n_errors = 0;

   bit              inj_a = 1'b0;
   bit              inj_b = 1'b0;
   logic [AB_B-1:0] inj_b_addr = '0;
   logic [DB_A-1:0] model_a [DEP_A];

   // March C- as a table: direction, expected read word, written word (-1 = none)
   int el_up [6] = '{1, 1, 1, 0, 0, 0};
   int el_rd [6] = '{-1, 0, 1, 0, 1, 0};
   int el_wr [6] = '{0, 1, 0, 1, 0, -1};

   // Stuck-at-1 cell: a bit forced high after every clock
   always @(negedge clk) if (inj_a) dut_a.mem[42][3] <= 1'b1;
   always @(negedge clk) if (inj_b) dut_b.mem[inj_b_addr][0] <= 1'b1;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int march_cycles(input int depth);
      int n = 0;
      for (int e = 0; e < 6; e++) n += depth * (((el_rd[e] >= 0) ? 1 : 0) + ((el_wr[e] >= 0) ? 1 : 0));
      return n;
   endfunction

   // First failing address of a run with one stuck-at-1 cell, -1 if clean
   function automatic int march_first_fail(input int depth, input int stuck);
      int word [];
      word = new[depth];
      for (int a = 0; a < depth; a++) word[a] = 0;
      for (int e = 0; e < 6; e++) begin
         for (int k = 0; k < depth; k++) begin
            int a;
            a = (el_up[e] != 0) ? k : depth - 1 - k;
            if (el_rd[e] >= 0) begin
               if ((word[a] != el_rd[e]) || ((a == stuck) && (el_rd[e] == 0))) return a;
            end
            if (el_wr[e] >= 0) word[a] = el_wr[e];
         end
      end
      return -1;
   endfunction

   task automatic run_bist(input bit on_b, input bit noise, input int abort_at, output int cycles);
      int          limit;
      logic [31:0] hold;
      limit  = 20 * DEP_A + 100;
      cycles = 0;
      if (on_b) ifb.start = 1'b1; else ifa.start = 1'b1;
      @(negedge clk);
      if (on_b) ifb.start = 1'b0; else ifa.start = 1'b0;
      check_value("start_clears_done", 32'(on_b ? ifb.done : ifa.done), 32'(0));
      check_value("start_clears_fail", 32'(on_b ? ifb.fail : ifa.fail), 32'(0));
      hold = on_b ? 32'(ifb.rdata) : 32'(ifa.rdata);
      while ((on_b ? ifb.busy : ifa.busy) && (cycles < limit)) begin
         cycles++;
         if ((abort_at > 0) && (cycles == abort_at)) begin
            ifa.we = 1'b0; ifa.start = 1'b0; ifb.we = 1'b0; ifb.start = 1'b0;
            reset = 1'b1;
            @(negedge clk);
            return;
         end
         if (noise) begin
            if (on_b) begin
               ifb.we    = 1'($urandom_range(1));
               ifb.start = 1'($urandom_range(1));
               ifb.addr  = AB_B'($urandom);
               ifb.wdata = DB_B'($urandom);
            end else begin
               ifa.we    = 1'($urandom_range(1));
               ifa.start = 1'($urandom_range(1));
               ifa.addr  = AB_A'($urandom);
               ifa.wdata = DB_A'($urandom);
            end
         end
         @(negedge clk);
      end
      ifa.we = 1'b0; ifa.start = 1'b0; ifb.we = 1'b0; ifb.start = 1'b0;
      check_value("rdata_hold_busy", on_b ? 32'(ifb.rdata) : 32'(ifa.rdata), hold);
   endtask

   task automatic read_all_zero(input bit on_b);
      int depth;
      depth = on_b ? DEP_B : DEP_A;
      for (int a = 0; a < depth; a++) begin
         if (on_b) ifb.addr = AB_B'(a); else ifa.addr = AB_A'(a);
         @(negedge clk);
         check_value("readback_zero", on_b ? 32'(ifb.rdata) : 32'(ifa.rdata), 32'(0));
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int              cyc;
      int              ff;
      logic [AB_A-1:0] ra;
      logic [DB_A-1:0] rw;
      logic [DB_A-1:0] exp8;
      bit              rwe;

      reset = 1'b1;
      ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0; ifa.start = 1'b0;
      ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0; ifb.start = 1'b0;
      repeat (2) @(negedge clk);
      check_value("rst_busy",      32'(ifa.busy),      32'(0));
      check_value("rst_done",      32'(ifa.done),      32'(0));
      check_value("rst_fail",      32'(ifa.fail),      32'(0));
      check_value("rst_fail_addr", 32'(ifa.fail_addr), 32'(0));
      check_value("rst_rdata",     32'(ifa.rdata),     32'(0));
      check_value("rst_busy_b",    32'(ifb.busy),      32'(0));
      reset = 1'b0;

      // Directed host write/read of 0xA5 at address 5
      ifa.we = 1'b1; ifa.addr = AB_A'(5); ifa.wdata = 8'h3C;
      @(negedge clk);
      ifa.wdata = 8'hA5;
      @(negedge clk);
      check_value("same_edge_old", 32'(ifa.rdata), 32'h3C);
      ifa.we = 1'b0;
      @(negedge clk);
      check_value("read_a5", 32'(ifa.rdata), 32'hA5);

      for (int a = 0; a < DEP_A; a++) begin
         model_a[a] = DB_A'($urandom);
         ifa.we = 1'b1; ifa.addr = AB_A'(a); ifa.wdata = model_a[a];
         @(negedge clk);
      end
      for (int i = 0; i < 200; i++) begin
         ra = AB_A'($urandom); rw = DB_A'($urandom); rwe = 1'($urandom_range(1));
         ifa.addr = ra; ifa.we = rwe; ifa.wdata = rw;
         exp8 = model_a[ra];
         if (rwe) model_a[ra] = rw;
         @(negedge clk);
         check_value("host_rw", 32'(ifa.rdata), 32'(exp8));
      end
      ifa.we = 1'b0;

      // Clean run on the 128-word instance
      run_bist(1'b0, 1'b0, 0, cyc);
      check_value("clean_cycles", 32'(cyc), 32'(march_cycles(DEP_A)));
      check_value("clean_done", 32'(ifa.done), 32'(1));
      check_value("clean_fail", 32'(ifa.fail), 32'(march_first_fail(DEP_A, -1) >= 0));
      read_all_zero(1'b0);

      // Host writes and restarts while busy must be ignored
      run_bist(1'b0, 1'b1, 0, cyc);
      check_value("noise_cycles", 32'(cyc), 32'(march_cycles(DEP_A)));
      check_value("noise_fail", 32'(ifa.fail), 32'(0));
      read_all_zero(1'b0);

      // Stuck-at-1 bit 3 at address 0x2A
      inj_a = 1'b1;
      run_bist(1'b0, 1'b0, 0, cyc);
      ff = march_first_fail(DEP_A, 42);
      check_value("fault_cycles", 32'(cyc), 32'(march_cycles(DEP_A)));
      check_value("fault_done", 32'(ifa.done), 32'(1));
      check_value("fault_fail", 32'(ifa.fail), 32'(ff >= 0));
      check_value("fault_addr", 32'(ifa.fail_addr), 32'(ff));
      repeat (5) @(negedge clk);
      check_value("sticky_done", 32'(ifa.done), 32'(1));
      check_value("sticky_fail", 32'(ifa.fail), 32'(1));
      check_value("sticky_addr", 32'(ifa.fail_addr), 32'(ff));

      // Reset inside M3 (M0 + M1 + M2 take 5*depth cycles)
      run_bist(1'b0, 1'b0, 5 * DEP_A + 10, cyc);
      check_value("abort_busy",  32'(ifa.busy),      32'(0));
      check_value("abort_done",  32'(ifa.done),      32'(0));
      check_value("abort_fail",  32'(ifa.fail),      32'(0));
      check_value("abort_faddr", 32'(ifa.fail_addr), 32'(0));
      check_value("abort_rdata", 32'(ifa.rdata),     32'(0));
      reset = 1'b0;
      inj_a = 1'b0;
      @(negedge clk);
      run_bist(1'b0, 1'b0, 0, cyc);
      check_value("rerun_cycles", 32'(cyc), 32'(march_cycles(DEP_A)));
      check_value("rerun_done", 32'(ifa.done), 32'(1));
      check_value("rerun_fail", 32'(ifa.fail), 32'(0));
      read_all_zero(1'b0);

      // Small instance: 4 words x 16 bits
      for (int a = 0; a < DEP_B; a++) begin
         ifb.we = 1'b1; ifb.addr = AB_B'(a); ifb.wdata = DB_B'($urandom);
         @(negedge clk);
      end
      ifb.we = 1'b0;
      run_bist(1'b1, 1'b1, 0, cyc);
      check_value("b_cycles", 32'(cyc), 32'(march_cycles(DEP_B)));
      check_value("b_done", 32'(ifb.done), 32'(1));
      check_value("b_fail", 32'(ifb.fail), 32'(0));
      read_all_zero(1'b1);

      for (int s = 0; s < 2; s++) begin
         inj_b_addr = (s == 0) ? AB_B'(DEP_B - 1) : AB_B'(0);
         inj_b = 1'b1;
         run_bist(1'b1, 1'b0, 0, cyc);
         ff = march_first_fail(DEP_B, int'(inj_b_addr));
         check_value("b_fault_fail", 32'(ifb.fail), 32'(ff >= 0));
         check_value("b_fault_addr", 32'(ifb.fail_addr), 32'(ff));
         inj_b = 1'b0;
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
`default_nettype wire
